// File: rtl/api_cmd_pkg.sv
// api_cmd_pkg: command codes, FSM encoding and default field widths for the API command engine.
package api_cmd_pkg;
  localparam int SLOT_W_D = 4;
  localparam int FPGA_W_D = 4;
  localparam int REG_W_D  = 8;
  localparam int CMD_W_D  = 8;
  localparam int DATA_W_D = 64;
  localparam logic [7:0] CMD_WRITE     = 8'h01;
  localparam logic [7:0] CMD_READ      = 8'h02;
  localparam logic [7:0] CMD_READ_RESP = 8'h03;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/api_reg_bank.sv
// api_reg_bank: register bank with write strobes, address-range check and read mux; reg 0 is a read-only ID.
module api_reg_bank #(
  parameter int REG_W = 8,
  parameter int DATA_W = 64,
  parameter int NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 64'h5345_0000_0000_0001
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [REG_W-1:0]             addr,
  input  logic [DATA_W-1:0]            wr_data,
  output logic [NUM_REGS*DATA_W-1:0]   q,
  output logic [NUM_REGS-1:0]          wr_stb,
  output logic [DATA_W-1:0]            rd_data,
  output logic                         wr_ok,
  output logic                         rd_ok
);
  localparam int AW = $clog2(NUM_REGS);
  logic [DATA_W-1:0] regs [NUM_REGS];
  logic [AW-1:0] idx;
  assign idx = addr[AW-1:0];
  assign rd_ok = {1'b0, addr} < (REG_W+1)'(NUM_REGS);
  assign wr_ok = rd_ok && addr != '0;
  assign rd_data = addr == '0 ? ID_VALUE : rd_ok ? regs[idx] : '0;
  // reg 0 storage is never written, so its slot in q stays zero
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      wr_stb <= '0;
    end else begin
      wr_stb <= '0;
      if (wr_en && wr_ok) begin
        regs[idx]   <= wr_data;
        wr_stb[idx] <= 1'b1;
      end
    end
  end
  for (genvar i = 0; i < NUM_REGS; i++) begin : g_q
    assign q[i*DATA_W +: DATA_W] = regs[i];
  end
endmodule

// File: rtl/api_reg_cmd_engine.sv
// api_reg_cmd_engine: pops API packets, executes WRITE/READ on a local register bank, returns read responses.
module api_reg_cmd_engine
  import api_cmd_pkg::*;
#(
  parameter int SLOT_W = SLOT_W_D,
  parameter int FPGA_W = FPGA_W_D,
  parameter int REG_W = REG_W_D,
  parameter int CMD_W = CMD_W_D,
  parameter int DATA_W = DATA_W_D,
  parameter int NUM_REGS = 16,
  parameter logic [DATA_W-1:0] ID_VALUE = 64'h5345_0000_0000_0001
) (
  input  logic                       api_clk_in,
  input  logic                       api_rst_n_in,
  input  logic [SLOT_W-1:0]          api_self_slot_in,
  input  logic [FPGA_W-1:0]          api_self_fpga_in,
  output logic                       api_i_clk_out,
  input  logic [SLOT_W-1:0]          api_i_src_slot_in,
  input  logic [FPGA_W-1:0]          api_i_src_fpga_in,
  input  logic [REG_W-1:0]           api_i_src_reg_in,
  input  logic [CMD_W-1:0]           api_i_src_cmd_in,
  input  logic [REG_W-1:0]           api_i_tgt_reg_in,
  input  logic [CMD_W-1:0]           api_i_tgt_cmd_in,
  input  logic [DATA_W-1:0]          api_i_data_in,
  input  logic                       api_i_empty_in,
  output logic                       api_i_rd_en_out,
  output logic                       api_o_clk_out,
  input  logic                       api_o_rfd_in,
  output logic [SLOT_W-1:0]          api_o_tgt_slot_out,
  output logic [FPGA_W-1:0]          api_o_tgt_fpga_out,
  output logic [REG_W-1:0]           api_o_tgt_reg_out,
  output logic [CMD_W-1:0]           api_o_tgt_cmd_out,
  output logic [REG_W-1:0]           api_o_src_reg_out,
  output logic [CMD_W-1:0]           api_o_src_cmd_out,
  output logic [DATA_W-1:0]          api_o_data_out,
  output logic                       api_o_wr_en_out,
  output logic [NUM_REGS*DATA_W-1:0] reg_q_out,
  output logic [NUM_REGS-1:0]        reg_wr_stb_out,
  output logic [15:0]                err_cnt_out,
  output logic [3:0]                 led_out
);
  typedef struct packed {
    logic [SLOT_W-1:0] src_slot;
    logic [FPGA_W-1:0] src_fpga;
    logic [REG_W-1:0]  src_reg;
    logic [CMD_W-1:0]  src_cmd;
    logic [REG_W-1:0]  tgt_reg;
    logic [CMD_W-1:0]  tgt_cmd;
    logic [DATA_W-1:0] data;
  } pkt_t;
  state_t state, state_nx;
  pkt_t pkt, head;
  logic pop, is_wr, is_rd, err, wr_ok, rd_ok, err_sticky;
  logic [DATA_W-1:0] rd_data;
  logic [25:0] hb;
  assign api_i_clk_out = api_clk_in;
  assign api_o_clk_out = api_clk_in;
  assign head = '{api_i_src_slot_in, api_i_src_fpga_in, api_i_src_reg_in, api_i_src_cmd_in,
                  api_i_tgt_reg_in, api_i_tgt_cmd_in, api_i_data_in};
  assign is_wr = pkt.tgt_cmd == CMD_W'(CMD_WRITE);
  assign is_rd = pkt.tgt_cmd == CMD_W'(CMD_READ);
  assign err = state == EXEC && (is_wr ? !wr_ok : is_rd ? !rd_ok : 1'b1);
  assign api_i_rd_en_out = pop;
  assign api_o_wr_en_out = state == RESP && api_o_rfd_in;
  assign led_out = {err_sticky, state == RESP, state != IDLE, hb[25]};
  // pop is gated by reset so a non-empty FIFO is never popped while held in reset
  always_comb begin
    state_nx = state;
    pop = 1'b0;
    case (state)
      IDLE: begin
        pop = api_rst_n_in && !api_i_empty_in;
        state_nx = pop ? EXEC : IDLE;
      end
      EXEC: state_nx = is_rd ? RESP : IDLE;
      RESP: state_nx = api_o_rfd_in ? IDLE : RESP;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge api_clk_in or negedge api_rst_n_in) begin
    if (!api_rst_n_in) begin
      state <= IDLE;
      pkt <= '0;
      hb <= '0;
      err_cnt_out <= '0;
      err_sticky <= 1'b0;
      api_o_tgt_slot_out <= '0;
      api_o_tgt_fpga_out <= '0;
      api_o_tgt_reg_out <= '0;
      api_o_tgt_cmd_out <= '0;
      api_o_src_reg_out <= '0;
      api_o_src_cmd_out <= '0;
      api_o_data_out <= '0;
    end else begin
      state <= state_nx;
      hb <= hb + 1'b1;
      if (pop) pkt <= head;
      if (err) err_sticky <= 1'b1;
      if (err && err_cnt_out != 16'hFFFF) err_cnt_out <= err_cnt_out + 1'b1;
      if (state == EXEC && is_rd) begin
        api_o_tgt_slot_out <= pkt.src_slot;
        api_o_tgt_fpga_out <= pkt.src_fpga;
        api_o_tgt_reg_out <= pkt.src_reg;
        api_o_tgt_cmd_out <= CMD_W'(CMD_READ_RESP);
        api_o_src_reg_out <= pkt.tgt_reg;
        api_o_src_cmd_out <= CMD_W'(CMD_READ_RESP);
        api_o_data_out <= rd_data;
      end
    end
  end
  api_reg_bank #(
    .REG_W(REG_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ID_VALUE(ID_VALUE)
  ) u_bank (
    .clk(api_clk_in),
    .rst_n(api_rst_n_in),
    .wr_en(state == EXEC && is_wr),
    .addr(pkt.tgt_reg),
    .wr_data(pkt.data),
    .q(reg_q_out),
    .wr_stb(reg_wr_stb_out),
    .rd_data(rd_data),
    .wr_ok(wr_ok),
    .rd_ok(rd_ok)
  );
endmodule

// File: tb/tb_api_reg_cmd_engine.sv
// tb_api_reg_cmd_engine: table-driven and sequence checks of the API register command engine.
module tb_api_reg_cmd_engine;
  localparam logic [63:0] ID = 64'h5345_0000_0000_0001;
  localparam logic [63:0] DB = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] A5 = 64'hA5A5_A5A5_5A5A_5A5A;
  logic clk = 1'b0, rst_n = 1'b0, rfd = 1'b0, empty = 1'b1, rd_en, wr_en, iclk, oclk;
  logic [3:0] i_slot = '0, i_fpga = '0, o_slot, o_fpga, led;
  logic [7:0] i_sreg = '0, i_scmd = '0, i_treg = '0, i_tcmd = '0, o_treg, o_tcmd, o_sreg, o_scmd;
  logic [63:0] i_data = '0, o_data;
  logic [1023:0] reg_q;
  logic [15:0] stb, err_cnt;
  always #5 clk = ~clk;
  api_reg_cmd_engine dut (
    .api_clk_in(clk), .api_rst_n_in(rst_n), .api_self_slot_in(4'd1), .api_self_fpga_in(4'd2),
    .api_i_clk_out(iclk), .api_i_src_slot_in(i_slot), .api_i_src_fpga_in(i_fpga),
    .api_i_src_reg_in(i_sreg), .api_i_src_cmd_in(i_scmd), .api_i_tgt_reg_in(i_treg),
    .api_i_tgt_cmd_in(i_tcmd), .api_i_data_in(i_data), .api_i_empty_in(empty),
    .api_i_rd_en_out(rd_en), .api_o_clk_out(oclk), .api_o_rfd_in(rfd),
    .api_o_tgt_slot_out(o_slot), .api_o_tgt_fpga_out(o_fpga), .api_o_tgt_reg_out(o_treg),
    .api_o_tgt_cmd_out(o_tcmd), .api_o_src_reg_out(o_sreg), .api_o_src_cmd_out(o_scmd),
    .api_o_data_out(o_data), .api_o_wr_en_out(wr_en), .reg_q_out(reg_q),
    .reg_wr_stb_out(stb), .err_cnt_out(err_cnt), .led_out(led)
  );
  typedef struct packed {
    logic [7:0] cmd; logic [7:0] rg; logic [3:0] slot; logic [3:0] fpga; logic [7:0] sreg; logic [63:0] data;
  } pkt_t;
  typedef struct packed {
    logic [3:0] slot; logic [3:0] fpga; logic [7:0] treg; logic [7:0] tcmd; logic [7:0] sreg; logic [7:0] scmd; logic [63:0] data;
  } resp_t;
  typedef struct {
    pkt_t p; bit resp; logic [63:0] edata; logic [15:0] estb; int eerr;
  } vec_t;
  pkt_t fifo[$];
  resp_t rq[$];
  logic [15:0] sh[$];
  int pc[$];
  int cyc = 0, pops = 0, checks = 0, errors = 0;
  logic rd_seen = 1'b0;
  // FWFT input FIFO model: pop what the DUT acknowledged, then present the new head
  always @(negedge clk) begin
    if (rd_seen && fifo.size() > 0) fifo.delete(0);
    empty = fifo.size() == 0;
    if (fifo.size() > 0) begin
      i_tcmd = fifo[0].cmd; i_treg = fifo[0].rg; i_slot = fifo[0].slot;
      i_fpga = fifo[0].fpga; i_sreg = fifo[0].sreg; i_data = fifo[0].data;
    end
  end
  always @(posedge clk) begin
    cyc++;
    rd_seen <= rd_en;
    if (rd_en) begin
      pops++;
      pc.push_back(cyc);
      if (empty) begin errors++; $display("FAIL rd_en_while_empty act=1 exp=0 cyc=%0d", cyc); end
    end
    if (wr_en) begin
      rq.push_back('{o_slot, o_fpga, o_treg, o_tcmd, o_sreg, o_scmd, o_data});
      if (!rfd) begin errors++; $display("FAIL wr_en_without_rfd act=1 exp=0 cyc=%0d", cyc); end
    end
    if (stb != '0) sh.push_back(stb);
  end
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  function automatic logic [63:0] rv(input int i);
    return reg_q[i*64 +: 64];
  endfunction
  function automatic vec_t mk(input logic [7:0] c, input logic [7:0] rg, input logic [3:0] s, input logic [3:0] f,
                              input logic [7:0] sr, input logic [63:0] d, input bit r, input logic [63:0] ed,
                              input logic [15:0] es, input int ee);
    vec_t v;
    v.p = '{c, rg, s, f, sr, d}; v.resp = r; v.edata = ed; v.estb = es; v.eerr = ee;
    return v;
  endfunction
  vec_t v[14];
  initial begin
    int nr, ns, np, npc;
    logic [15:0] so;
    logic [63:0] snap;
    resp_t r;
    v[0]  = mk(8'h01, 8'd5,  4'd1, 4'd1, 8'd1,  DB,           0, 64'h0, 16'h0020, 0);
    v[1]  = mk(8'h02, 8'd5,  4'd2, 4'd3, 8'd7,  64'h0,        1, DB,    16'h0000, 0);
    v[2]  = mk(8'h02, 8'd0,  4'd4, 4'd5, 8'd9,  64'h0,        1, ID,    16'h0000, 0);
    v[3]  = mk(8'h01, 8'd0,  4'd1, 4'd1, 8'd1,  64'h1111,     0, 64'h0, 16'h0000, 1);
    v[4]  = mk(8'h01, 8'd20, 4'd1, 4'd1, 8'd1,  64'h2222,     0, 64'h0, 16'h0000, 2);
    v[5]  = mk(8'h02, 8'd20, 4'd6, 4'd7, 8'h21, 64'h0,        1, 64'h0, 16'h0000, 3);
    v[6]  = mk(8'h7F, 8'd1,  4'd1, 4'd1, 8'd1,  64'h3333,     0, 64'h0, 16'h0000, 4);
    v[7]  = mk(8'h01, 8'd15, 4'd1, 4'd1, 8'd1,  A5,           0, 64'h0, 16'h8000, 4);
    v[8]  = mk(8'h02, 8'd15, 4'hF, 4'hE, 8'hFF, 64'h0,        1, A5,    16'h0000, 4);
    v[9]  = mk(8'h01, 8'd1,  4'd1, 4'd1, 8'd1,  64'h1,        0, 64'h0, 16'h0002, 4);
    v[10] = mk(8'h02, 8'd16, 4'd0, 4'd0, 8'd0,  64'h0,        1, 64'h0, 16'h0000, 5);
    v[11] = mk(8'h02, 8'd1,  4'd1, 4'd2, 8'd3,  64'h0,        1, 64'h1, 16'h0000, 5);
    v[12] = mk(8'h03, 8'd1,  4'd1, 4'd1, 8'd1,  64'h4444,     0, 64'h0, 16'h0000, 6);
    v[13] = mk(8'h00, 8'd2,  4'd1, 4'd1, 8'd1,  64'h5555,     0, 64'h0, 16'h0000, 7);
    repeat (3) @(negedge clk);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_regq", |reg_q, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_led", led, 0);
    chk("rst_tgt_cmd", o_tcmd, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("idle_no_pop", pops, 0);
    rfd = 1'b1;
    for (int i = 0; i < 14; i++) begin
      nr = rq.size(); ns = sh.size();
      fifo.push_back(v[i].p);
      repeat (8) @(negedge clk);
      so = '0;
      for (int k = ns; k < sh.size(); k++) so |= sh[k];
      chk($sformatf("v%0d_err", i), err_cnt, v[i].eerr);
      chk($sformatf("v%0d_stb", i), so, v[i].estb);
      chk($sformatf("v%0d_nstb", i), sh.size() - ns, v[i].estb != 0);
      chk($sformatf("v%0d_nresp", i), rq.size() - nr, v[i].resp);
      if (v[i].resp && rq.size() > nr) begin
        r = rq[nr];
        chk($sformatf("v%0d_data", i), r.data, v[i].edata);
        chk($sformatf("v%0d_slot", i), r.slot, v[i].p.slot);
        chk($sformatf("v%0d_fpga", i), r.fpga, v[i].p.fpga);
        chk($sformatf("v%0d_treg", i), r.treg, v[i].p.sreg);
        chk($sformatf("v%0d_tcmd", i), r.tcmd, 8'h03);
        chk($sformatf("v%0d_sreg", i), r.sreg, v[i].p.rg);
        chk($sformatf("v%0d_scmd", i), r.scmd, 8'h03);
      end
    end
    chk("bank_r0", rv(0), 0);
    chk("bank_r1", rv(1), 1);
    chk("bank_r2", rv(2), 0);
    chk("bank_r4", rv(4), 0);
    chk("bank_r5", rv(5), DB);
    chk("bank_r15", rv(15), A5);
    chk("led_sticky", led[3], 1);
    rfd = 1'b0;
    nr = rq.size(); np = pops;
    fifo.push_back('{8'h02, 8'd5, 4'd1, 4'd1, 8'd10, 64'h0});
    fifo.push_back('{8'h02, 8'd15, 4'd1, 4'd1, 8'd11, 64'h0});
    fifo.push_back('{8'h02, 8'd1, 4'd1, 4'd1, 8'd12, 64'h0});
    repeat (5) @(negedge clk);
    snap = o_data;
    repeat (45) @(negedge clk);
    chk("bp_pops", pops - np, 1);
    chk("bp_no_resp", rq.size() - nr, 0);
    chk("bp_data_stable", o_data, snap);
    chk("bp_data", o_data, DB);
    chk("bp_treg", o_treg, 10);
    chk("bp_led_pend", led[2], 1);
    rfd = 1'b1;
    repeat (15) @(negedge clk);
    chk("bp_nresp", rq.size() - nr, 3);
    if (rq.size() - nr == 3) begin
      chk("bp_r0_data", rq[nr].data, DB);
      chk("bp_r0_treg", rq[nr].treg, 10);
      chk("bp_r1_data", rq[nr+1].data, A5);
      chk("bp_r1_treg", rq[nr+1].treg, 11);
      chk("bp_r2_data", rq[nr+2].data, 1);
      chk("bp_r2_treg", rq[nr+2].treg, 12);
    end
    np = pops; npc = pc.size(); ns = sh.size();
    for (int i = 0; i < 8; i++) fifo.push_back('{8'h01, 8'(i + 1), 4'd1, 4'd1, 8'd1, 64'h100 + 64'(i)});
    repeat (25) @(negedge clk);
    chk("b2b_pops", pops - np, 8);
    chk("b2b_nstb", sh.size() - ns, 8);
    if (sh.size() - ns == 8 && pc.size() - npc == 8) begin
      for (int k = 0; k < 8; k++) chk($sformatf("b2b_stb%0d", k), sh[ns+k], 16'(1) << (k + 1));
      for (int k = 1; k < 8; k++) chk($sformatf("b2b_gap%0d", k), pc[npc+k] - pc[npc+k-1], 2);
    end
    for (int k = 0; k < 8; k++) chk($sformatf("b2b_reg%0d", k + 1), rv(k + 1), 64'h100 + 64'(k));
    rfd = 1'b0;
    fifo.push_back('{8'h02, 8'd3, 4'd1, 4'd1, 8'd1, 64'h0});
    for (int k = 0; k < 20 && !led[2]; k++) @(negedge clk);
    chk("rr_pending", led[2], 1);
    rst_n = 1'b0;
    fifo.push_back('{8'h02, 8'd4, 4'd1, 4'd1, 8'd1, 64'h0});
    #1;
    chk("rr_wr_en", wr_en, 0);
    chk("rr_rd_en", rd_en, 0);
    chk("rr_regq", |reg_q, 0);
    chk("rr_err", err_cnt, 0);
    chk("rr_led", led, 0);
    chk("rr_data", o_data, 0);
    chk("rr_treg", o_treg, 0);
    chk("rr_stb", stb, 0);
    rfd = 1'b1;
    nr = rq.size(); np = pops;
    repeat (3) @(negedge clk);
    chk("rr_hold_rd_en", rd_en, 0);
    fifo.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("rr_no_pop", pops - np, 0);
    chk("rr_no_resp", rq.size() - nr, 0);
    chk("rr_reg3", rv(3), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/api_reg_cmd_engine.md
Name: api_reg_cmd_engine

Overview:
- Packet-level command engine inside the template main block, placed between the SciEngines API input FIFO (api_i_*) and output port (api_o_*).
- Pops incoming packets and executes WRITE/READ commands against a local register bank.
- Returns read responses to the packet's source slot/FPGA/register.
- Exposes the register bank and write strobes to user logic, and status bits to the LEDs.

Parameters:
- SLOT_W, 4, slot address width (matches C_LENGTH_ADDR_SLOT)
- FPGA_W, 4, FPGA address width (matches C_LENGTH_ADDR_FPGA)
- REG_W, 8, register address width (matches C_LENGTH_ADDR_REG)
- CMD_W, 8, command width (matches C_LENGTH_CMD)
- DATA_W, 64, data width (matches C_LENGTH_DATA)
- NUM_REGS, 16, implemented registers, 2..2**REG_W; reg 0 is a read-only ID
- ID_VALUE, 64'h5345_0000_0000_0001, value returned when reg 0 is read

Ports:
- api_clk_in  in  1  sole clock
- api_rst_n_in  in  1  asynchronous, active-low reset
- api_self_slot_in  in  SLOT_W  own slot address; stable after reset
- api_self_fpga_in  in  FPGA_W  own FPGA address
- api_i_clk_out  out  1  equals api_clk_in
- api_i_src_slot_in / api_i_src_fpga_in / api_i_src_reg_in / api_i_src_cmd_in  in  SLOT_W/FPGA_W/REG_W/CMD_W  head-packet source fields
- api_i_tgt_reg_in / api_i_tgt_cmd_in  in  REG_W/CMD_W  head-packet target register and command
- api_i_data_in  in  DATA_W  head-packet payload
- api_i_empty_in  in  1  input FIFO empty (first-word-fall-through: head fields valid while low)
- api_i_rd_en_out  out  1  pops the head packet
- api_o_clk_out  out  1  equals api_clk_in
- api_o_rfd_in  in  1  output ready-for-data
- api_o_tgt_slot_out / api_o_tgt_fpga_out / api_o_tgt_reg_out / api_o_tgt_cmd_out  out  widths as above  response destination
- api_o_src_reg_out / api_o_src_cmd_out  out  REG_W/CMD_W  response source register and command
- api_o_data_out  out  DATA_W  response payload
- api_o_wr_en_out  out  1  one-cycle write into the output port
- reg_q_out  out  NUM_REGS*DATA_W  flattened register bank; reg i occupies bits [i*DATA_W +: DATA_W]
- reg_wr_stb_out  out  NUM_REGS  one-cycle pulse on the register index just written
- err_cnt_out  out  16  count of rejected packets; saturates at 16'hFFFF
- led_out  out  4  {err_sticky, resp_pending, busy, heartbeat}

Behaviour:
- Reset (async assert, sync release). All outputs go to 0 except the clock passthroughs. Registers 1..NUM_REGS-1 reset to 0. FSM goes to IDLE.
- Commands: CMD_WRITE=8'h01, CMD_READ=8'h02, CMD_READ_RESP=8'h03.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If api_i_empty_in=0: capture all head fields into a packet register, assert api_i_rd_en_out for exactly this one cycle, go to EXEC.
  - Otherwise stay in IDLE.
- EXEC (acts on the captured packet):
  - WRITE with 1 <= reg < NUM_REGS: reg <= data; reg_wr_stb_out[reg]=1 for one cycle (registered, so it is visible one cycle after EXEC, together with the new reg_q). Go to IDLE.
  - WRITE to reg 0 or reg >= NUM_REGS: dropped, err_cnt +1, go to IDLE.
  - READ: response data = ID_VALUE if reg 0; reg value if reg < NUM_REGS; 0 with err_cnt +1 otherwise. Go to RESP.
  - Any other command: err_cnt +1, go to IDLE.
- RESP: hold all api_o_* fields stable.
  - When api_o_rfd_in=1: assert api_o_wr_en_out for one cycle, go to IDLE.
  - Otherwise wait indefinitely; no new packet is popped meanwhile.
- Response field mapping: tgt_slot/tgt_fpga = captured src_slot/src_fpga; tgt_reg = captured src_reg; tgt_cmd = CMD_READ_RESP; src_reg = captured tgt_reg; src_cmd = CMD_READ_RESP.
- Throughput: one packet per 2 cycles for writes; 3 cycles minimum for reads.
- api_i_rd_en_out is never asserted while api_i_empty_in=1, and never asserted outside IDLE.
- api_o_wr_en_out is never asserted while api_o_rfd_in=0.
- err_sticky sets on any error and clears only on reset.
- heartbeat = bit 25 of a free-running counter.
- Reset mid-RESP: the pending response is discarded and api_o_wr_en_out stays 0.

Decomposition:
- Package api_cmd_pkg holds CMD_WRITE/CMD_READ/CMD_READ_RESP, the state encoding, and default widths.
- Natural sub-module: api_reg_bank, holding the registers, strobes, address-range check, and read mux.
- The FSM stays in api_reg_cmd_engine.

Test Plan:
- Reset: hold api_rst_n_in=0 mid-traffic -> all outputs 0, reg_q_out=0. Release -> idle, with no rd_en while empty=1.
- Write then read: WRITE reg 5 data 64'hDEAD_BEEF_0123_4567, then READ reg 5 from src slot 2 / FPGA 3 / reg 7 -> reg_wr_stb_out=16'h0020 for one cycle; response has tgt slot 2 / FPGA 3 / reg 7, cmd 8'h03, src_reg 5, data 64'hDEAD_BEEF_0123_4567.
- ID read: READ reg 0 -> data = ID_VALUE, err_cnt unchanged.
- Errors: WRITE reg 0, WRITE reg 20, READ reg 20, cmd 8'h7F -> err_cnt=4, READ reg 20 response data 0, led_out[3]=1, reg bank unchanged.
- Backpressure: hold rfd=0 for 50 cycles with 3 READs queued -> exactly one pop, fields stable, no wr_en. rfd=1 -> three responses in order.
- Back-to-back: 8 WRITEs with empty held low -> rd_en every other cycle, 8 strobes, no lost or duplicated packets.
